// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch port, data port and memory port of the arbiter, plus the abort flag.
// Latency: wires only, so it adds no cycles.
// Backpressure: none of its own. Requesters hold req until ack, and the memory finishes an access with a one-cycle m_ack.
// Ports: i_* is the instruction-fetch requester, d_* is the data requester, m_* is the single-port memory, err is the abort flag.
// Modports: master is the arbiter side (drives acks, read data, memory strobes and err). slave is the environment side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: lets the MIPS fetch port and data port share one single-port memory, and aborts accesses that hang.
// Latency: the request is seen in IDLE at cycle t, m_en rises at t+1, m_ack comes at t+k, and ack pulses at t+k+1. Throughput is one access per k+2 cycles.
// Backpressure: a requester holds req until its ack. Only one access is in flight, and a loser of arbitration waits in IDLE.
// Ports: clk and reset (async, active-high). The bus modport master carries the i_*/d_* requester ports, the m_* memory port and err.
// Option: with ARB_RR_EN defined, simultaneous requests alternate between ports. Without it, data always beats instruction.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q, state_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic [7:0]        cnt_inc;
    logic              sel_d_q, sel_d_nxt;    // port being served: 1 = data
    logic              last_d_q, last_d_nxt;  // port served last: 1 = data
    logic              pick_d;

    logic              m_en_q, m_en_nxt;
    logic              m_we_q, m_we_nxt;
    logic [ADDR_W-1:0] m_addr_q, m_addr_nxt;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_nxt;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
    logic              i_ack_q, i_ack_nxt;
    logic              d_ack_q, d_ack_nxt;
    logic              err_q, err_nxt;

    assign cnt_inc = cnt_q + 8'd1;

`ifdef ARB_RR_EN
    // On a tie, the port that was not served last wins. After reset the data port wins first.
    assign pick_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
    // Data wins every tie, because a stalled MEM stage freezes the whole pipeline.
    assign pick_d = bus.d_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            sel_d_q   <= 1'b0;
            last_d_q  <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            sel_d_q   <= sel_d_nxt;
            last_d_q  <= last_d_nxt;
            m_en_q    <= m_en_nxt;
            m_we_q    <= m_we_nxt;
            m_addr_q  <= m_addr_nxt;
            m_wdata_q <= m_wdata_nxt;
            i_rdata_q <= i_rdata_nxt;
            d_rdata_q <= d_rdata_nxt;
            i_ack_q   <= i_ack_nxt;
            d_ack_q   <= d_ack_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        sel_d_nxt   = sel_d_q;
        last_d_nxt  = last_d_q;
        m_en_nxt    = m_en_q;
        m_we_nxt    = m_we_q;
        m_addr_nxt  = m_addr_q;
        m_wdata_nxt = m_wdata_q;
        i_rdata_nxt = i_rdata_q;
        d_rdata_nxt = d_rdata_q;
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        err_nxt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    cnt_nxt   = 8'd0;
                    m_en_nxt  = 1'b1;
                    sel_d_nxt = pick_d;
                    if (pick_d) begin
                        m_we_nxt    = bus.d_we;
                        m_addr_nxt  = bus.d_addr;
                        m_wdata_nxt = bus.d_wdata;
                        state_nxt   = BUSY_D;
                    end else begin
                        m_we_nxt    = 1'b0;
                        m_addr_nxt  = bus.i_addr;
                        m_wdata_nxt = '0;
                        state_nxt   = BUSY_I;
                    end
                end
            end

            BUSY_I, BUSY_D: begin
                cnt_nxt = cnt_inc;
                // The ack is registered here, so it shows up during RESP.
                // If m_ack lands on the timeout cycle, it counts as a normal completion.
                if (bus.m_ack) begin
                    m_en_nxt  = 1'b0;
                    state_nxt = RESP;
                    if (state_q == BUSY_D) begin
                        d_rdata_nxt = bus.m_rdata;
                        d_ack_nxt   = 1'b1;
                    end else begin
                        i_rdata_nxt = bus.m_rdata;
                        i_ack_nxt   = 1'b1;
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    m_en_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                    if (state_q == BUSY_D) begin
                        d_rdata_nxt = '0;
                        d_ack_nxt   = 1'b1;
                    end else begin
                        i_rdata_nxt = '0;
                        i_ack_nxt   = 1'b1;
                    end
                end
            end

            RESP: begin
                // Requests are not looked at here, so a requester may drop or change req during its ack cycle.
                last_d_nxt = sel_d_q;
                state_nxt  = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed checks of the memory-port arbiter. It covers single accesses, timeouts, contention order, stray acks and reset in the middle of an access.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays both requesters and the memory, and answers m_en after k cycles as each vector specifies.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;     // word the memory returns
        int          k;          // cycles from m_en to m_ack; 0 means the memory never acks
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_men(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.m_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_m_en: m_en still %b after 4 cycles, expected 1", bus.m_en);
        end
    endtask

    logic [31:0] exp_i_rd;
    logic [31:0] exp_d_rd;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0; bus.m_ack = 1'b0;
        exp_i_rd = '0;
        exp_d_rd = '0;

        //                  is_d we  addr     wdata          mrdata         k   exp_rdata      err
        vecs[0] = '{1'b0, 1'b0, 10'h004, 32'hFFFF_FFFF, 32'h8C01_0000, 2,  32'h8C01_0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 10'h010, 32'h0000_002A, 32'h1111_1111, 1,  32'h1111_1111, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 10'h3FF, 32'h0000_0055, 32'hDEAD_BEEF, 3,  32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 10'h020, 32'h0000_0000, 32'h7777_7777, 0,  32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 10'h008, 32'h1234_0000, 32'h1234_5678, 1,  32'h1234_5678, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 10'h000, 32'h0000_0000, 32'hCAFE_F00D, 15, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 10'h155, 32'h0000_0001, 32'hA5A5_A5A5, 14, 32'hA5A5_A5A5, 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Every output should hold its reset value.
        chk("rst_m_en",    {31'd0, bus.m_en},  32'd0);
        chk("rst_m_we",    {31'd0, bus.m_we},  32'd0);
        chk("rst_m_addr",  {22'd0, bus.m_addr}, 32'd0);
        chk("rst_m_wdata", bus.m_wdata, 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_acks",    {29'd0, bus.i_ack, bus.d_ack, bus.err}, 32'd0);

        // Single-requester vectors.
        for (int v = 0; v < 7; v++) begin
            int n_hold;
            n_hold = (vecs[v].k == 0) ? TIMEOUT : vecs[v].k;
            bus.i_req   = !vecs[v].is_d;
            bus.d_req   = vecs[v].is_d;
            bus.i_addr  = vecs[v].addr;
            bus.d_addr  = vecs[v].addr;
            bus.d_we    = vecs[v].we;
            bus.d_wdata = vecs[v].wdata;
            tick();  // grant edge: cycle t+1
            chk($sformatf("v%0d_m_en_t1", v), {31'd0, bus.m_en}, 32'd1);
            chk($sformatf("v%0d_m_addr", v), {22'd0, bus.m_addr}, {22'd0, vecs[v].addr});
            chk($sformatf("v%0d_m_we", v), {31'd0, bus.m_we}, {31'd0, vecs[v].is_d & vecs[v].we});
            chk($sformatf("v%0d_m_wdata", v), bus.m_wdata, vecs[v].is_d ? vecs[v].wdata : 32'd0);
            for (int j = 1; j < n_hold; j++) begin
                tick();
                chk($sformatf("v%0d_m_en_hold%0d", v, j), {31'd0, bus.m_en}, 32'd1);
                chk($sformatf("v%0d_m_wdata_hold%0d", v, j), bus.m_wdata,
                    vecs[v].is_d ? vecs[v].wdata : 32'd0);
            end
            if (vecs[v].k != 0) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = vecs[v].mrdata;
            end
            tick();
            bus.m_ack = 1'b0;
            if (vecs[v].is_d) exp_d_rd = vecs[v].exp_rdata;
            else              exp_i_rd = vecs[v].exp_rdata;
            chk($sformatf("v%0d_i_ack", v), {31'd0, bus.i_ack}, {31'd0, !vecs[v].is_d});
            chk($sformatf("v%0d_d_ack", v), {31'd0, bus.d_ack}, {31'd0, vecs[v].is_d});
            chk($sformatf("v%0d_err", v), {31'd0, bus.err}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_m_en_off", v), {31'd0, bus.m_en}, 32'd0);
            chk($sformatf("v%0d_i_rdata", v), bus.i_rdata, exp_i_rd);
            chk($sformatf("v%0d_d_rdata", v), bus.d_rdata, exp_d_rd);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            tick();
            chk($sformatf("v%0d_ack_single", v), {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
            chk($sformatf("v%0d_err_single", v), {31'd0, bus.err}, 32'd0);
        end

        // A stray m_ack while idle must be ignored.
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hBAD0_BAD0;
        tick();
        bus.m_ack = 1'b0;
        chk("stray_acks", {29'd0, bus.i_ack, bus.d_ack, bus.err}, 32'd0);
        chk("stray_m_en", {31'd0, bus.m_en}, 32'd0);
        tick();
        chk("stray_acks2", {29'd0, bus.i_ack, bus.d_ack, bus.err}, 32'd0);
        chk("stray_i_rdata", bus.i_rdata, exp_i_rd);
        chk("stray_d_rdata", bus.d_rdata, exp_d_rd);

        // Contention: both requests held from the start.
        begin
            bit          exp_order[4];
            int          d_done;
            bit          ok;
`ifdef ARB_RR_EN
            exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
            exp_order = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
            d_done = 0;
            bus.i_req  = 1'b1; bus.i_addr = 10'h040;
            bus.d_req  = 1'b1; bus.d_addr = 10'h050; bus.d_we = 1'b0; bus.d_wdata = 32'd0;
            for (int n = 0; n < 4; n++) begin
                wait_men(ok);
                if (ok) begin
                    chk($sformatf("cont%0d_m_addr", n), {22'd0, bus.m_addr},
                        exp_order[n] ? 32'h050 : 32'h040);
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = 32'h1000 + n;
                    tick();
                    bus.m_ack = 1'b0;
                    chk($sformatf("cont%0d_d_ack", n), {31'd0, bus.d_ack}, {31'd0, exp_order[n]});
                    chk($sformatf("cont%0d_i_ack", n), {31'd0, bus.i_ack}, {31'd0, !exp_order[n]});
                    if (exp_order[n]) d_done++;
`ifndef ARB_RR_EN
                    if (d_done == 3) bus.d_req = 1'b0;
`endif
                end
            end
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            tick();
        end

        // Reset in the middle of a fetch.
        begin
            bit ok;
            tick();
            bus.i_req  = 1'b1;
            bus.i_addr = 10'h0AA;
            tick();
            chk("rma_m_en_busy", {31'd0, bus.m_en}, 32'd1);
            tick();
            #2 reset = 1'b1;
            #1;
            chk("rma_m_en_async", {31'd0, bus.m_en}, 32'd0);
            chk("rma_i_ack", {31'd0, bus.i_ack}, 32'd0);
            tick();
            chk("rma_i_ack_hold", {31'd0, bus.i_ack}, 32'd0);
            reset = 1'b0;
            wait_men(ok);
            if (ok) begin
                chk("rma_m_addr", {22'd0, bus.m_addr}, 32'h0AA);
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'h600D_F00D;
                tick();
                bus.m_ack = 1'b0;
                chk("rma_i_ack_done", {31'd0, bus.i_ack}, 32'd1);
                chk("rma_i_rdata", bus.i_rdata, 32'h600D_F00D);
                chk("rma_err", {31'd0, bus.err}, 32'd0);
            end
            bus.i_req = 1'b0;
            tick();
            chk("rma_i_ack_single", {31'd0, bus.i_ack}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
